// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add 8x8 multiply.
// Results and {Z,N,C} flags are registered toward writeback; stall holds the
// upstream ID/EX register while a multiply is being accepted or is running.
module ex_stage #(
  parameter int MUL_STEPS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] in_opcode,
  input  logic [1:0] in_rd,
  input  logic [7:0] in_data1,
  input  logic [7:0] in_data2,
  output logic       out_wen,
  output logic [1:0] out_rd,
  output logic [7:0] out_result,
  output logic [2:0] out_flags,
  output logic       stall,
  output logic       busy
);

  localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MOV = 4'd11;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [15:0]   acc_reg;
  logic [15:0]   mcand_reg;
  logic [7:0]    mplier_reg;
  logic [1:0]    rd_cap_reg;

  logic [15:0]   acc_next;
  logic [8:0]    sum9, diff9, shl9, shr9;
  logic [7:0]    alu_result;
  logic          alu_carry;
  logic          alu_wen;
  logic          alu_upd_result;
  logic          alu_upd_flags;
  logic [2:0]    alu_flags;
  logic          mul_last;

  // Partial-product accumulate for the current multiply step
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : 16'd0);
  assign mul_last = (cnt_reg == LAST_STEP);

  // Hold upstream while a MUL is presented in IDLE or before its final step
  assign stall = ((state_reg == IDLE) && (in_opcode == OP_MUL)) ||
                 ((state_reg == BUSY) && !mul_last);

  // 9-bit helpers: bit 8 of add/sub is carry/borrow; shifts expose the last bit out
  assign sum9  = {1'b0, in_data1} + {1'b0, in_data2};
  assign diff9 = {1'b0, in_data1} - {1'b0, in_data2};
  assign shl9  = {1'b0, in_data1} << in_data2[2:0];
  assign shr9  = {in_data1, 1'b0} >> in_data2[2:0];

  // Single-cycle ALU decode: result, carry and which outputs get updated
  always_comb begin
    alu_result     = 8'd0;
    alu_carry      = 1'b0;
    alu_wen        = 1'b0;
    alu_upd_result = 1'b0;
    alu_upd_flags  = 1'b0;
    case (in_opcode)
      OP_ADD: begin alu_result = sum9[7:0];  alu_carry = sum9[8];  alu_wen = 1'b1; alu_upd_result = 1'b1; alu_upd_flags = 1'b1; end
      OP_SUB: begin alu_result = diff9[7:0]; alu_carry = diff9[8]; alu_wen = 1'b1; alu_upd_result = 1'b1; alu_upd_flags = 1'b1; end
      OP_AND: begin alu_result = in_data1 & in_data2; alu_wen = 1'b1; alu_upd_result = 1'b1; alu_upd_flags = 1'b1; end
      OP_OR:  begin alu_result = in_data1 | in_data2; alu_wen = 1'b1; alu_upd_result = 1'b1; alu_upd_flags = 1'b1; end
      OP_XOR: begin alu_result = in_data1 ^ in_data2; alu_wen = 1'b1; alu_upd_result = 1'b1; alu_upd_flags = 1'b1; end
      OP_NOT: begin alu_result = ~in_data1;           alu_wen = 1'b1; alu_upd_result = 1'b1; alu_upd_flags = 1'b1; end
      OP_SHL: begin alu_result = shl9[7:0]; alu_carry = shl9[8]; alu_wen = 1'b1; alu_upd_result = 1'b1; alu_upd_flags = 1'b1; end
      OP_SHR: begin alu_result = shr9[8:1]; alu_carry = shr9[0]; alu_wen = 1'b1; alu_upd_result = 1'b1; alu_upd_flags = 1'b1; end
      // CMP updates flags only; the difference never reaches out_result
      OP_CMP: begin alu_result = diff9[7:0]; alu_carry = diff9[8]; alu_upd_flags = 1'b1; end
      OP_MOV: begin alu_result = in_data2; alu_wen = 1'b1; alu_upd_result = 1'b1; end
      default: begin end
    endcase
    alu_flags = {(alu_result == 8'd0), alu_result[7], alu_carry};
  end

  // Pipeline register, IDLE/BUSY control and the shift-add multiply iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= 16'd0;
      mcand_reg  <= 16'd0;
      mplier_reg <= 8'd0;
      rd_cap_reg <= 2'd0;
      out_wen    <= 1'b0;
      out_rd     <= 2'd0;
      out_result <= 8'd0;
      out_flags  <= 3'd0;
      busy       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_opcode == OP_MUL) begin
            mcand_reg  <= {8'd0, in_data1};
            mplier_reg <= in_data2;
            acc_reg    <= 16'd0;
            cnt_reg    <= '0;
            rd_cap_reg <= in_rd;
            out_wen    <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= BUSY;
          end else begin
            out_wen <= alu_wen;
            out_rd  <= in_rd;
            if (alu_upd_result) out_result <= alu_result;
            if (alu_upd_flags)  out_flags  <= alu_flags;
          end
        end
        BUSY: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CW'(1);
          out_wen    <= 1'b0;
          if (mul_last) begin
            out_result <= acc_next[7:0];
            out_flags  <= {(acc_next[7:0] == 8'd0), acc_next[7], (acc_next[15:8] != 8'd0)};
            out_rd     <= rd_cap_reg;
            out_wen    <= 1'b1;
            busy       <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: hand-computed vectors for ALU ops, MUL timing,
// back-to-back MUL/ADD and reset during a multiply.
module tb_ex_stage;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_opcode;
  logic [1:0] in_rd;
  logic [7:0] in_data1;
  logic [7:0] in_data2;
  logic       out_wen;
  logic [1:0] out_rd;
  logic [7:0] out_result;
  logic [2:0] out_flags;
  logic       stall;
  logic       busy;

  int vec_count = 0;
  int miscompares = 0;

  ex_stage #(.MUL_STEPS(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .out_wen   (out_wen),
    .out_rd    (out_rd),
    .out_result(out_result),
    .out_flags (out_flags),
    .stall     (stall),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] rd,
                       input logic [7:0] a, input logic [7:0] b);
    in_opcode = op;
    in_rd     = rd;
    in_data1  = a;
    in_data2  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic wen, input logic [1:0] rd,
                           input logic [7:0] res, input logic [2:0] fl);
    check({tag, "_wen"},    16'(out_wen),    16'(wen));
    check({tag, "_rd"},     16'(out_rd),     16'(rd));
    check({tag, "_result"}, 16'(out_result), 16'(res));
    check({tag, "_flags"},  16'(out_flags),  16'(fl));
  endtask

  int stall_cnt, busy_cnt, wen_cnt;
  bit done;

  initial begin
    reset_n = 1'b0;
    drive(4'd0, 2'd0, 8'd0, 8'd0);
    #12;
    check_out("reset", 1'b0, 2'd0, 8'h00, 3'b000);
    check("reset_busy", 16'(busy), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // ADD rd=2 0xF0+0x20 -> 0x10, C=1
    drive(4'd1, 2'd2, 8'hF0, 8'h20);
    #1 check("add_stall", 16'(stall), 16'd0);
    tick();
    check_out("add", 1'b1, 2'd2, 8'h10, 3'b001);

    // SUB 5-5 -> 0, Z=1
    drive(4'd2, 2'd1, 8'h05, 8'h05);
    tick();
    check_out("sub", 1'b1, 2'd1, 8'h00, 3'b100);

    // CMP 3 vs 7 -> flags N=1 C=1, result unchanged, no write
    drive(4'd10, 2'd3, 8'h03, 8'h07);
    tick();
    check_out("cmp", 1'b0, 2'd3, 8'h00, 3'b011);

    // SHL 0x81<<1 -> 0x02, C=1
    drive(4'd7, 2'd0, 8'h81, 8'h01);
    tick();
    check_out("shl", 1'b1, 2'd0, 8'h02, 3'b001);

    // SHR 0x81>>0 -> 0x81, C=0, N=1
    drive(4'd8, 2'd1, 8'h81, 8'h00);
    tick();
    check_out("shr", 1'b1, 2'd1, 8'h81, 3'b010);

    // Reserved opcode behaves as NOP: no write, result and flags held
    drive(4'd13, 2'd2, 8'hAA, 8'h55);
    tick();
    check_out("rsvd", 1'b0, 2'd2, 8'h81, 3'b010);

    // MOV: result=B, flags held
    drive(4'd11, 2'd3, 8'h00, 8'h5A);
    tick();
    check_out("mov", 1'b1, 2'd3, 8'h5A, 3'b010);

    // MUL rd=1 0x13*0x11 = 0x0143, held during stall
    drive(4'd9, 2'd1, 8'h13, 8'h11);
    stall_cnt = 0; busy_cnt = 0; wen_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (busy) busy_cnt++;
      if (i > 0 && out_wen) wen_cnt++;
      tick();
    end
    check("mul1_stall_cycles", 16'(stall_cnt), 16'd8);
    check("mul1_busy_cycles",  16'(busy_cnt),  16'd8);
    check("mul1_bubble_wen",   16'(wen_cnt),   16'd0);
    check_out("mul1", 1'b1, 2'd1, 8'h43, 3'b001);
    check("mul1_busy_after", 16'(busy), 16'd0);
    drive(4'd0, 2'd0, 8'h00, 8'h00);
    tick();
    check("mul1_wen_once", 16'(out_wen), 16'd0);

    // MUL 0x0F*0x0F = 0xE1, then ADD as soon as stall drops
    drive(4'd9, 2'd2, 8'h0F, 8'h0F);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else tick();
    end
    check("mul2_completed", 16'(done), 16'd1);
    tick();
    check_out("mul2", 1'b1, 2'd2, 8'hE1, 3'b010);
    drive(4'd1, 2'd3, 8'h01, 8'h02);
    #1 check("mul2_add_stall", 16'(stall), 16'd0);
    tick();
    check_out("mul2_add", 1'b1, 2'd3, 8'h03, 3'b000);
    drive(4'd0, 2'd0, 8'h00, 8'h00);
    tick();
    check("mul2_add_once", 16'(out_wen), 16'd0);

    // Reset in BUSY with cnt=4 aborts the multiply
    drive(4'd9, 2'd1, 8'h03, 8'h05);
    for (int i = 0; i < 5; i++) tick();
    check("rst_mid_busy", 16'(busy), 16'd1);
    drive(4'd0, 2'd0, 8'h00, 8'h00);
    reset_n = 1'b0;
    #1;
    check_out("rst_mid", 1'b0, 2'd0, 8'h00, 3'b000);
    check("rst_mid_busy_clr", 16'(busy), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("rst_release_stall", 16'(stall), 16'd0);
    wen_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_wen) wen_cnt++;
    end
    check("rst_no_mul_write", 16'(wen_cnt), 16'd0);
    check("rst_result_clear", 16'(out_result), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
